// File: rtl/ss_corr_mc_if.sv
// Register bus, sample stream and correlation output of ss_corr_mc.
// The slave modport is the correlator's view; the master modport is the driver's view.
interface ss_corr_mc_if #(
  parameter int SAMP_W = 12,
  parameter int ACC_W  = 32,
  parameter int CH_W   = 2
);
  logic [31:0]       din;
  logic [31:0]       dout;
  logic [3:0]        addr;
  logic              strobe;
  logic [SAMP_W-1:0] samp;
  logic              push_samp;
  logic              sync;
  logic              push_corr;
  logic [ACC_W-1:0]  corr;
  logic [CH_W-1:0]   corr_ch;

  modport master (
    output din, addr, strobe, samp, push_samp, sync,
    input  dout, push_corr, corr, corr_ch
  );

  modport slave (
    input  din, addr, strobe, samp, push_samp, sync,
    output dout, push_corr, corr, corr_ch
  );
endinterface

// File: rtl/ss_corr_mc.sv
// Multi-channel spread spectrum correlator: one sample stream against N_CH PN codes,
// with per-period results serialized (optionally magnitude-gated) onto a shared output.
module ss_corr_mc #(
  parameter int SAMP_W   = 12,
  parameter int N_CH     = 4,
  parameter int CODE_LEN = 32,
  parameter int ACC_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  ss_corr_mc_if.slave  bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CI_W  = $clog2(CODE_LEN);
  localparam int CMP_W = (ACC_W > 32) ? ACC_W : 32;

  typedef enum logic {IDLE, EMIT} ser_state_t;
  ser_state_t state, state_next;

  logic [CODE_LEN-1:0]     code [N_CH];
  logic [N_CH-1:0]         ch_en;
  logic                    thr_en;
  logic [31:0]             thresh;
  logic [15:0]             period_cnt;
  logic [CI_W-1:0]         chip_idx;
  logic signed [ACC_W-1:0] acc      [N_CH];
  logic signed [ACC_W-1:0] acc_next [N_CH];
  logic signed [ACC_W-1:0] hold     [N_CH];
  logic signed [ACC_W-1:0] samp_ext;
  logic [ACC_W-1:0]        mag;
  logic [N_CH-1:0]         qual, pend, pend_next;
  logic                    accept, period_end, emit;
  logic [CH_W-1:0]         emit_ch;
  logic [31:0]             rd_data;

  // Correlation datapath and threshold qualification of the would-be hold values
  always_comb begin
    accept     = bus.push_samp & ~bus.sync;
    period_end = accept && (chip_idx == CI_W'(CODE_LEN - 1));
    samp_ext   = {{(ACC_W-SAMP_W){bus.samp[SAMP_W-1]}}, bus.samp};
    qual       = '0;
    mag        = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      acc_next[i] = code[i][chip_idx] ? acc[i] + samp_ext : acc[i] - samp_ext;
      mag         = acc_next[i][ACC_W-1] ? -acc_next[i] : acc_next[i];
      qual[i]     = ch_en[i] && (!thr_en || (CMP_W'(mag) >= CMP_W'(thresh)));
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (bus.addr == 4'(i)) rd_data = 32'(code[i]);
    case (bus.addr)
      4'd8:    rd_data = {15'b0, thr_en, 16'(ch_en)};
      4'd9:    rd_data = thresh;
      4'd10:   rd_data = {8'b0, 8'(chip_idx), period_cnt};
      default: ;
    endcase
  end

  // Serializer: pend holds the still-to-emit qualified channels; lowest set bit goes next.
  // A period end reloads pend; the previous batch is always drained by then.
  always_comb begin
    state_next = state;
    pend_next  = pend;
    emit       = 1'b0;
    emit_ch    = '0;
    if (state == EMIT) begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (pend[i] && !emit) begin
          emit    = 1'b1;
          emit_ch = CH_W'(i);
        end
      pend_next = pend & (pend - N_CH'(1));
      if (pend_next == '0) state_next = IDLE;
    end
    if (period_end) begin
      pend_next  = qual;
      state_next = (qual != '0) ? EMIT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        code[i] <= '0;
        acc[i]  <= '0;
        hold[i] <= '0;
      end
      ch_en         <= '1;
      thr_en        <= 1'b0;
      thresh        <= '0;
      period_cnt    <= '0;
      chip_idx      <= '0;
      bus.dout      <= '0;
      bus.push_corr <= 1'b0;
      bus.corr      <= '0;
      bus.corr_ch   <= '0;
    end else begin
      bus.dout <= rd_data;
      if (bus.strobe) begin
        for (int unsigned i = 0; i < N_CH; i++)
          if (bus.addr == 4'(i)) code[i] <= bus.din[CODE_LEN-1:0];
        if (bus.addr == 4'd8) begin
          ch_en  <= bus.din[N_CH-1:0];
          thr_en <= bus.din[16];
        end
        if (bus.addr == 4'd9) thresh <= bus.din;
      end

      if (bus.sync) begin
        chip_idx <= '0;
        for (int unsigned i = 0; i < N_CH; i++) acc[i] <= '0;
      end else if (accept) begin
        chip_idx <= period_end ? '0 : chip_idx + CI_W'(1);
        for (int unsigned i = 0; i < N_CH; i++)
          acc[i] <= period_end ? '0 : acc_next[i];
        if (period_end) begin
          hold       <= acc_next;
          period_cnt <= period_cnt + 16'd1;
        end
      end

      bus.push_corr <= emit;
      if (emit) begin
        bus.corr    <= hold[emit_ch];
        bus.corr_ch <= emit_ch;
      end
    end
  end
endmodule
